// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl
// Brief   : HALT/STEP/RUN debug controller driving a CPU clock enable, with
//           PC breakpoints, a retire counter and an optional retire-trace FIFO
//           compiled in by defining CPU_STEP_TRACE_EN.
// Revision: 1.0
// ============================================================================
module cpu_step_ctrl #(
  parameter int XLEN        = 32,
  parameter int BP_NUM      = 2,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_req,
  input  logic                     run_req,
  input  logic                     halt_req,
  input  logic [CNT_W-1:0]         step_cnt,
  input  logic [BP_NUM-1:0]        bp_en,
  input  logic [BP_NUM*XLEN-1:0]   bp_addr,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     fetch_i,
  output logic                     cpu_ce,
  output logic                     halted,
  output logic [BP_NUM-1:0]        bp_hit,
  output logic [CNT_W-1:0]         retired,
  input  logic                     trace_rd,
  output logic [XLEN-1:0]          trace_pc,
  output logic [31:0]              trace_inst,
  output logic                     trace_empty,
  output logic                     trace_full,
  output logic                     trace_ovf
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [BP_NUM-1:0] bp_hit_q, bp_hit_d;
  logic              step_dly_q, run_dly_q;
  logic [BP_NUM-1:0] bp_match;
  logic              step_edge, run_edge, retire;

  assign step_edge = step_req & ~step_dly_q;
  assign run_edge  = run_req & ~run_dly_q;
  assign retire    = (state_q != ST_HALT) & fetch_i;

  genvar g;
  for (g = 0; g < BP_NUM; g++) begin : g_bp
    assign bp_match[g] = bp_en[g] && (pc_i == bp_addr[g*XLEN +: XLEN]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      remaining_q <= '0;
      retired_q   <= '0;
      bp_hit_q    <= '0;
      step_dly_q  <= 1'b0;
      run_dly_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      retired_q   <= retired_d;
      bp_hit_q    <= bp_hit_d;
      step_dly_q  <= step_req;
      run_dly_q   <= run_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bp_hit_d    = bp_hit_q;
    retired_d   = retired_q + CNT_W'(retire);
    case (state_q)
      ST_HALT: begin
        if (!halt_req) begin
          if (step_edge) begin
            state_d     = ST_STEP;
            remaining_d = (step_cnt == '0) ? CNT_W'(1) : step_cnt;
            bp_hit_d    = '0;
          end else if (run_edge) begin
            state_d  = ST_RUN;
            bp_hit_d = '0;
          end
        end
      end
      ST_STEP: begin
        if (retire) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = ST_HALT;
          if (|bp_match) begin
            bp_hit_d = bp_hit_q | bp_match;
            state_d  = ST_HALT;
          end
        end
      end
      ST_RUN: begin
        if (retire && |bp_match) begin
          bp_hit_d = bp_hit_q | bp_match;
          state_d  = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (halt_req) state_d = ST_HALT;
  end

  always_comb begin
    cpu_ce  = (state_q != ST_HALT);
    halted  = (state_q == ST_HALT);
    bp_hit  = bp_hit_q;
    retired = retired_q;
  end

`ifdef CPU_STEP_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN+31:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             t_empty, t_full, t_pop, t_push;
  logic [XLEN+31:0] rd_data;

  assign t_empty = (count_q == '0);
  assign t_full  = (count_q == CW'(TRACE_DEPTH));
  assign t_pop   = trace_rd & ~t_empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign t_push  = retire & (~t_full | t_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(t_push);
    rd_ptr_d = rd_ptr_q + AW'(t_pop);
    count_d  = count_q + CW'(t_push) - CW'(t_pop);
    ovf_d    = ovf_q | (retire & t_full & ~t_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (t_push) mem_q[wr_ptr_q] <= {pc_i, inst_i};
  end

  always_comb begin
    trace_empty = t_empty;
    trace_full  = t_full;
    trace_ovf   = ovf_q;
    trace_pc    = t_empty ? '0 : rd_data[XLEN+31:32];
    trace_inst  = t_empty ? '0 : rd_data[31:0];
  end
`else
  logic unused_trace;
  assign unused_trace = ^{trace_rd, inst_i, TRACE_DEPTH[0]};

  always_comb begin
    trace_empty = 1'b1;
    trace_full  = 1'b0;
    trace_ovf   = 1'b0;
    trace_pc    = '0;
    trace_inst  = '0;
  end
`endif

endmodule
`default_nettype wire
